// File: rtl/score_pkg.sv
// Shared types and helpers for the BCD score counter.
package score_pkg;

    // Sequencer states: wait for work, ripple one digit per clock, publish.
    typedef enum logic [1:0] {
        IDLE_ST   = 2'd0,
        CALC_ST   = 2'd1,
        COMMIT_ST = 2'd2
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;

    // Force an out-of-range nibble (A..F) to the largest legal BCD digit.
    function automatic bcd_t bcd_clamp(input bcd_t d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_digit_alu.sv
// One-digit BCD adder/subtractor; the top reuses it for every digit position.
module bcd_digit_alu
    import score_pkg::*;
(
    input  bcd_t a,
    input  bcd_t b,
    input  logic cin,
    input  logic sub,
    output bcd_t y,
    output logic cout
);

    logic [4:0] sum;
    logic [4:0] diff;

    // Binary result first, then decimal correction: +6 past 9 on add, +10 on a borrow.
    always_comb begin
        sum  = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
        diff = {1'b0, a} - {1'b0, b} - {4'b0000, cin};
        y    = '0;
        cout = 1'b0;
        if (sub) begin
            // diff[4] is the sign of a-b-cin; the result never drops below -10.
            if (diff[4]) begin
                y    = diff[3:0] + 4'd10;
                cout = 1'b1;
            end else begin
                y    = diff[3:0];
            end
        end else begin
            if (sum > 5'd9) begin
                y    = sum[3:0] + 4'd6;
                cout = 1'b1;
            end else begin
                y    = sum[3:0];
            end
        end
    end

endmodule

// File: rtl/bcd_score_counter.sv
// N-digit packed BCD score/shot counter, serviced one digit per clock, with
// saturation at 0 and all-nines, priority reload, and digit placement outputs.
module bcd_score_counter
    import score_pkg::*;
#(
    parameter int                  DIGITS    = 3,
    parameter logic [DIGITS*4-1:0] START_BCD = (DIGITS*4)'('h100),
    parameter int                  X0        = 70,
    parameter int                  Y0        = 300,
    parameter int                  PITCH     = 22,
    parameter int                  LABEL_X   = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  dec_evt,
    input  logic [3:0]            dec_amount,
    input  logic                  inc_evt,
    input  logic [3:0]            inc_amount,
    input  logic                  load,
    input  logic [DIGITS*4-1:0]   load_value,
    input  logic                  freeze,
    output logic [DIGITS*4-1:0]   digits,
    output logic [DIGITS*11-1:0]  digit_x,
    output logic [10:0]           digit_y,
    output logic [10:0]           label_x,
    output logic [10:0]           label_y,
    output logic                  empty,
    output logic                  busy,
    output logic                  overrun,
    output state_t                state_dbg
);

    localparam int W = DIGITS * 4;

    // Event protocol: dec_evt/inc_evt are levels; each 0->1 transition seen while
    // freeze is low is one request. Each direction has a single pending slot; a
    // request arriving while its slot is occupied is lost and flagged on overrun.
    // load wins over everything and cancels pending and in-flight work.

    state_t          state;
    logic [W-1:0]    digits_r;
    logic [W-1:0]    work;
    logic [2:0]      idx;
    logic            cy;
    logic            op_sub;
    bcd_t            op_amt;
    logic            dec_q;
    logic            inc_q;
    logic            pend_dec;
    logic            pend_inc;
    bcd_t            dec_amt_r;
    bcd_t            inc_amt_r;
    logic            empty_r;
    logic            overrun_r;
    logic [W-1:0]    load_clamped;
    logic [DIGITS*11-1:0] digit_x_r;
    logic [10:0]     digit_y_r;
    logic [10:0]     label_x_r;
    logic [10:0]     label_y_r;

    logic            dec_edge;
    logic            inc_edge;
    bcd_t            alu_a;
    bcd_t            alu_b;
    bcd_t            alu_y;
    logic            alu_cout;

    assign dec_edge = dec_evt & ~dec_q & ~freeze;
    assign inc_edge = inc_evt & ~inc_q & ~freeze;

    // Current digit and operand: the amount only enters at the LSD, higher digits just ripple.
    assign alu_a = work[4*int'(idx) +: 4];
    assign alu_b = (idx == 3'd0) ? op_amt : 4'd0;

    bcd_digit_alu u_alu (
        .a    (alu_a),
        .b    (alu_b),
        .cin  (cy),
        .sub  (op_sub),
        .y    (alu_y),
        .cout (alu_cout)
    );

    // Sanitize each reload nibble so the committed value is always legal BCD.
    always_comb begin
        load_clamped = '0;
        for (int i = 0; i < DIGITS; i++) begin
            load_clamped[4*i +: 4] = bcd_clamp(load_value[4*i +: 4]);
        end
    end

    // Edge capture, pending slots, and the IDLE/CALC/COMMIT sequencer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE_ST;
            digits_r  <= START_BCD;
            empty_r   <= (START_BCD == '0);
            overrun_r <= 1'b0;
            pend_dec  <= 1'b0;
            pend_inc  <= 1'b0;
            dec_q     <= 1'b0;
            inc_q     <= 1'b0;
            dec_amt_r <= '0;
            inc_amt_r <= '0;
            work      <= '0;
            idx       <= '0;
            cy        <= 1'b0;
            op_sub    <= 1'b0;
            op_amt    <= '0;
        end else begin
            dec_q     <= dec_evt;
            inc_q     <= inc_evt;
            overrun_r <= 1'b0;
            if (load) begin
                // Edges coincident with a reload are discarded along with everything pending.
                digits_r <= load_clamped;
                empty_r  <= (load_clamped == '0);
                state    <= IDLE_ST;
                pend_dec <= 1'b0;
                pend_inc <= 1'b0;
            end else begin
                case (state)
                    IDLE_ST: begin
                        if (pend_dec) begin
                            work     <= digits_r;
                            op_sub   <= 1'b1;
                            op_amt   <= dec_amt_r;
                            pend_dec <= 1'b0;
                            idx      <= '0;
                            cy       <= 1'b0;
                            state    <= CALC_ST;
                        end else if (pend_inc) begin
                            work     <= digits_r;
                            op_sub   <= 1'b0;
                            op_amt   <= inc_amt_r;
                            pend_inc <= 1'b0;
                            idx      <= '0;
                            cy       <= 1'b0;
                            state    <= CALC_ST;
                        end
                    end
                    CALC_ST: begin
                        work[4*int'(idx) +: 4] <= alu_y;
                        cy  <= alu_cout;
                        idx <= idx + 3'd1;
                        if (idx == 3'(DIGITS - 1)) begin
                            state <= COMMIT_ST;
                        end
                    end
                    COMMIT_ST: begin
                        // A carry/borrow out of the MSD means the true result is out of range.
                        if (cy) begin
                            digits_r <= op_sub ? '0 : {DIGITS{4'h9}};
                            empty_r  <= op_sub;
                        end else begin
                            digits_r <= work;
                            empty_r  <= (work == '0);
                        end
                        state <= IDLE_ST;
                    end
                    default: state <= IDLE_ST;
                endcase

                // A slot already occupied (even if being consumed this cycle) drops the new edge.
                if (dec_edge) begin
                    if (pend_dec) begin
                        overrun_r <= 1'b1;
                    end else begin
                        pend_dec  <= 1'b1;
                        dec_amt_r <= bcd_clamp(dec_amount);
                    end
                end
                if (inc_edge) begin
                    if (pend_inc) begin
                        overrun_r <= 1'b1;
                    end else begin
                        pend_inc  <= 1'b1;
                        inc_amt_r <= bcd_clamp(inc_amount);
                    end
                end
            end
        end
    end

    // Screen placement is fixed by parameters; captured at reset and held.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DIGITS; i++) begin
                digit_x_r[11*i +: 11] <= 11'(X0 + (DIGITS - 1 - i) * PITCH);
            end
            digit_y_r <= 11'(Y0);
            label_x_r <= 11'(LABEL_X);
            label_y_r <= 11'(Y0);
        end
    end

    assign digits    = digits_r;
    assign empty     = empty_r;
    assign overrun   = overrun_r;
    assign busy      = (state != IDLE_ST);
    assign state_dbg = state;
    assign digit_x   = digit_x_r;
    assign digit_y   = digit_y_r;
    assign label_x   = label_x_r;
    assign label_y   = label_y_r;

endmodule

// File: tb/tb_bcd_score_counter.sv
// Directed plus randomized bench for bcd_score_counter against an integer score model.
module tb_bcd_score_counter;

    localparam int D    = 3;
    localparam int MAXV = 999;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          dec_evt = 1'b0;
    logic [3:0]    dec_amount = '0;
    logic          inc_evt = 1'b0;
    logic [3:0]    inc_amount = '0;
    logic          load = 1'b0;
    logic [11:0]   load_value = '0;
    logic          freeze = 1'b0;
    logic [11:0]   digits;
    logic [32:0]   digit_x;
    logic [10:0]   digit_y;
    logic [10:0]   label_x;
    logic [10:0]   label_y;
    logic          empty;
    logic          busy;
    logic          overrun;
    score_pkg::state_t st_dbg;

    // Two-digit instance for narrow-width reload clamping and saturation.
    logic          b_inc_evt = 1'b0;
    logic [3:0]    b_inc_amount = '0;
    logic          b_load = 1'b0;
    logic [7:0]    b_load_value = '0;
    logic [7:0]    b_digits;
    logic [21:0]   b_digit_x;
    logic [10:0]   b_digit_y;
    logic [10:0]   b_label_x;
    logic [10:0]   b_label_y;
    logic          b_empty;
    logic          b_busy;
    logic          b_overrun;
    score_pkg::state_t b_st_dbg;

    int checks = 0;
    int errors = 0;
    int model  = 100;

    bcd_score_counter #(.DIGITS(3), .START_BCD(12'h100)) dut (
        .clk(clk), .reset(reset),
        .dec_evt(dec_evt), .dec_amount(dec_amount),
        .inc_evt(inc_evt), .inc_amount(inc_amount),
        .load(load), .load_value(load_value), .freeze(freeze),
        .digits(digits), .digit_x(digit_x), .digit_y(digit_y),
        .label_x(label_x), .label_y(label_y),
        .empty(empty), .busy(busy), .overrun(overrun), .state_dbg(st_dbg)
    );

    bcd_score_counter #(.DIGITS(2), .START_BCD(8'h42)) dut_b (
        .clk(clk), .reset(reset),
        .dec_evt(1'b0), .dec_amount(4'd0),
        .inc_evt(b_inc_evt), .inc_amount(b_inc_amount),
        .load(b_load), .load_value(b_load_value), .freeze(1'b0),
        .digits(b_digits), .digit_x(b_digit_x), .digit_y(b_digit_y),
        .label_x(b_label_x), .label_y(b_label_y),
        .empty(b_empty), .busy(b_busy), .overrun(b_overrun), .state_dbg(b_st_dbg)
    );

    // Clock
    always #5 clk = ~clk;

    // Model helpers: scores as plain integers, BCD only at the boundary.
    function automatic logic [31:0] to_bcd(input int v, input int nd);
        logic [31:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < nd; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int clamped_value(input logic [31:0] v, input int nd);
        int r;
        int p;
        int n;
        r = 0;
        p = 1;
        for (int i = 0; i < nd; i++) begin
            n = int'(v[4*i +: 4]);
            if (n > 9) n = 9;
            r = r + n * p;
            p = p * 10;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_value(input string tag);
        check({tag, "_digits"}, 32'(digits), to_bcd(model, D));
        check({tag, "_empty"}, 32'(empty), 32'(model == 0));
    endtask

    // Drivers: inputs change on the falling edge, outputs sampled on the falling edge.
    task automatic fire(input bit is_dec, input int amt);
        @(negedge clk);
        if (is_dec) begin dec_evt = 1'b1; dec_amount = 4'(amt); end
        else        begin inc_evt = 1'b1; inc_amount = 4'(amt); end
        @(negedge clk);
        dec_evt = 1'b0;
        inc_evt = 1'b0;
    endtask

    task automatic do_load(input logic [11:0] v);
        @(negedge clk);
        load = 1'b1;
        load_value = v;
        @(negedge clk);
        load = 1'b0;
        model = clamped_value(32'(v), D);
    endtask

    task automatic apply_op(input bit is_dec, input int amt);
        fire(is_dec, amt);
        repeat (D + 2) @(negedge clk);
        if (is_dec) model = (model - amt < 0) ? 0 : model - amt;
        else        model = (model + amt > MAXV) ? MAXV : model + amt;
    endtask

    initial begin
        // Reset
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_value("reset");
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_overrun", 32'(overrun), 32'd0);
        check("b_reset_digits", 32'(b_digits), 32'h42);
        for (int i = 0; i < D; i++) begin
            check($sformatf("digit_x%0d", i), 32'(digit_x[11*i +: 11]), 32'(70 + (D - 1 - i) * 22));
        end
        check("digit_y", 32'(digit_y), 32'd300);
        check("label_x", 32'(label_x), 32'd3);
        check("label_y", 32'(label_y), 32'd300);

        // 100 - 1: exact latency and busy window
        fire(1'b1, 1);
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            check($sformatf("lat_busy_n%0d", n), 32'(busy), 32'd1);
            check($sformatf("lat_hold_n%0d", n), 32'(digits), 32'h100);
        end
        @(negedge clk);
        model = 99;
        check_value("dec_100_1");
        check("lat_busy_done", 32'(busy), 32'd0);

        // Underflow saturation and recovery
        do_load(12'h005);
        check_value("load_005");
        apply_op(1'b1, 7);
        check_value("sat_zero");
        apply_op(1'b0, 3);
        check_value("inc_003");

        // Overflow saturation and middle-digit carry ripple
        do_load(12'h995);
        apply_op(1'b0, 9);
        check_value("sat_999");
        do_load(12'h099);
        apply_op(1'b0, 1);
        check_value("ripple_100");

        // Simultaneous edges: dec first, then inc
        do_load(12'h050);
        @(negedge clk);
        dec_evt = 1'b1; dec_amount = 4'd1;
        inc_evt = 1'b1; inc_amount = 4'd4;
        @(negedge clk);
        dec_evt = 1'b0;
        inc_evt = 1'b0;
        repeat (5) @(negedge clk);
        model = 49;
        check_value("simul_dec");
        repeat (5) @(negedge clk);
        model = 53;
        check_value("simul_inc");

        // Overrun: second dec edge while the dec slot is still occupied
        fire(1'b0, 1);
        @(negedge clk);
        dec_evt = 1'b1; dec_amount = 4'd2;
        @(negedge clk);
        dec_evt = 1'b0;
        @(negedge clk);
        dec_evt = 1'b1; dec_amount = 4'd5;
        @(negedge clk);
        check("overrun_pulse", 32'(overrun), 32'd1);
        dec_evt = 1'b0;
        @(negedge clk);
        check("overrun_clear", 32'(overrun), 32'd0);
        model = 54;
        check_value("overrun_inc");
        repeat (5) @(negedge clk);
        model = 52;
        check_value("overrun_dec");
        repeat (4) @(negedge clk);
        check_value("overrun_nodrop");
        check("overrun_idle", 32'(busy), 32'd0);

        // Load during CALC discards the in-flight subtract
        fire(1'b1, 1);
        @(negedge clk);
        @(negedge clk);
        check("calc_busy", 32'(busy), 32'd1);
        load = 1'b1;
        load_value = 12'h250;
        @(negedge clk);
        load = 1'b0;
        model = 250;
        check_value("load_in_calc");
        check("load_busy", 32'(busy), 32'd0);
        repeat (6) @(negedge clk);
        check_value("load_discard");

        // Narrow instance: clamp on reload and saturation at 99
        @(negedge clk);
        b_load = 1'b1;
        b_load_value = 8'hA3;
        @(negedge clk);
        b_load = 1'b0;
        check("b_load_clamp", 32'(b_digits), 32'h93);
        b_inc_evt = 1'b1;
        b_inc_amount = 4'd9;
        @(negedge clk);
        b_inc_evt = 1'b0;
        repeat (4) @(negedge clk);
        check("b_sat_99", 32'(b_digits), 32'h99);

        // Freeze: edges ignored, nothing queued for later
        freeze = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            dec_evt = 1'b1; dec_amount = 4'd3;
            @(negedge clk);
            dec_evt = 1'b0;
            check($sformatf("freeze_busy%0d", i), 32'(busy), 32'd0);
        end
        @(negedge clk);
        freeze = 1'b0;
        repeat (8) @(negedge clk);
        check_value("freeze_hold");
        check("freeze_idle", 32'(busy), 32'd0);

        // Reset in the middle of CALC
        fire(1'b1, 1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model = 100;
        check_value("reset_mid_calc");
        check("reset_mid_busy", 32'(busy), 32'd0);
        repeat (6) @(negedge clk);
        check_value("reset_mid_settle");

        // Randomized mix of reloads, adds and subtracts
        for (int it = 0; it < 40; it++) begin
            int r;
            int amt;
            r = int'($urandom_range(0, 9));
            amt = int'($urandom_range(0, 9));
            if (r == 0) begin
                do_load(12'($urandom_range(0, 4095)));
                check_value($sformatf("rnd_load%0d", it));
            end else begin
                apply_op(r < 5, amt);
                check_value($sformatf("rnd_op%0d", it));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
